// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, decoder states and key mapping for the two-player PS/2 front end
package ps2_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int PAUSE_LEN = 7;
    localparam int NKEYS     = 10;

    localparam int K_P1_UP    = 0;
    localparam int K_P1_DOWN  = 1;
    localparam int K_P1_LEFT  = 2;
    localparam int K_P1_RIGHT = 3;
    localparam int K_P1_FIRE  = 4;
    localparam int K_P2_UP    = 5;
    localparam int K_P2_DOWN  = 6;
    localparam int K_P2_LEFT  = 7;
    localparam int K_P2_RIGHT = 8;
    localparam int K_P2_FIRE  = 9;

    typedef enum logic [2:0] {
        NORMAL,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE_SKIP
    } dec_state_t;

    // One-hot key selected by an exact (extended, code) pair; zero when unmapped
    function automatic logic [NKEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
        key_mask = '0;
        if (!ext) begin
            case (code)
                SC_W:     key_mask[K_P1_UP]    = 1'b1;
                SC_S:     key_mask[K_P1_DOWN]  = 1'b1;
                SC_A:     key_mask[K_P1_LEFT]  = 1'b1;
                SC_D:     key_mask[K_P1_RIGHT] = 1'b1;
                SC_SPACE: key_mask[K_P1_FIRE]  = 1'b1;
                SC_ENTER: key_mask[K_P2_FIRE]  = 1'b1;
                default:  key_mask = '0;
            endcase
        end else begin
            case (code)
                SC_UP:    key_mask[K_P2_UP]    = 1'b1;
                SC_DOWN:  key_mask[K_P2_DOWN]  = 1'b1;
                SC_LEFT:  key_mask[K_P2_LEFT]  = 1'b1;
                SC_RIGHT: key_mask[K_P2_RIGHT] = 1'b1;
                default:  key_mask = '0;
            endcase
        end
    endfunction

    // Keyboard status replies and overflow codes that carry no key meaning
    function automatic logic is_reply(input logic [7:0] code);
        return code == 8'hAA || code == 8'hFA || code == 8'hEE ||
               code == 8'hFE || code == 8'h00 || code == 8'hFF;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 pad conditioning and 11-bit frame receiver with mid-frame timeout
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       valid,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_s, dat_s;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    sr;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          fall;

    // The filtered clock drops this cycle: a full run of low samples while high
    assign fall = filt && !clk_s[1] && fcnt == FW'(FILTER_LEN - 1);

    // Two-flop synchronizers for both asynchronous pads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s <= '0;
            dat_s <= '0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_dat};
        end
    end

    // Glitch filter: level follows the pad only after FILTER_LEN disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            fcnt <= '0;
        end else if (clk_s[1] == filt) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt <= ~filt;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    // Frame shifter: start, eight data bits LSB first, odd parity, stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            sr      <= '0;
            par     <= 1'b0;
            tcnt    <= '0;
            code    <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (bit_cnt == 4'd0) begin
                    bit_cnt <= dat_s[1] ? 4'd0 : 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    sr      <= {dat_s[1], sr[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par     <= dat_s[1];
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= '0;
                    if (dat_s[1] && (^{par, sr})) begin
                        code  <= sr;
                        valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (bit_cnt == 4'd0) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                err     <= 1'b1;
                bit_cnt <= '0;
                tcnt    <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_player_keys.sv
// ps2_player_keys: PS/2 keyboard decoded into held direction/fire levels for two players
module ps2_player_keys
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_p1_up,
    output logic       o_p1_down,
    output logic       o_p1_left,
    output logic       o_p1_right,
    output logic       o_p1_fire,
    output logic       o_p2_up,
    output logic       o_p2_down,
    output logic       o_p2_left,
    output logic       o_p2_right,
    output logic       o_p2_fire,
    output logic [7:0] o_scan_code,
    output logic       o_scan_valid,
    output logic       o_frame_err
);

    localparam int SW = $clog2(PAUSE_LEN + 1);

    dec_state_t       state;
    logic [SW-1:0]    skip;
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] mask;
    logic             ext, brk;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .ps2_clk(i_ps2_clk),
        .ps2_dat(i_ps2_dat),
        .code   (o_scan_code),
        .valid  (o_scan_valid),
        .err    (o_frame_err)
    );

    assign ext  = state == EXT || state == EXT_BRK;
    assign brk  = state == BRK || state == EXT_BRK;
    assign mask = key_mask(ext, o_scan_code);

    // Prefix tracking and key hold registers, stepped once per received byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
            skip  <= '0;
            keys  <= '0;
        end else if (o_scan_valid) begin
            if (state == PAUSE_SKIP) begin
                skip <= skip + 1'b1;
                if (skip == SW'(PAUSE_LEN - 1)) begin
                    state <= NORMAL;
                    skip  <= '0;
                end
            end else if (o_scan_code == SC_E0) begin
                state <= EXT;
            end else if (o_scan_code == SC_F0) begin
                state <= ext ? EXT_BRK : BRK;
            end else if (o_scan_code == SC_E1) begin
                state <= PAUSE_SKIP;
                skip  <= '0;
            end else begin
                state <= NORMAL;
                if (!(state == NORMAL && is_reply(o_scan_code)))
                    keys <= brk ? keys & ~mask : keys | mask;
            end
        end
    end

    assign {o_p2_fire, o_p2_right, o_p2_left, o_p2_down, o_p2_up,
            o_p1_fire, o_p1_right, o_p1_left, o_p1_down, o_p1_up} = keys;

endmodule

// File: tb/tb_ps2_player_keys.sv
// tb_ps2_player_keys: directed PS/2 frame stimulus with hand-computed key expectations
module tb_ps2_player_keys;

    localparam int HP   = 40;
    localparam int IDLE = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       o_p1_up, o_p1_down, o_p1_left, o_p1_right, o_p1_fire;
    logic       o_p2_up, o_p2_down, o_p2_left, o_p2_right, o_p2_fire;
    logic [7:0] o_scan_code;
    logic       o_scan_valid, o_frame_err;
    logic [9:0] keys;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int vcyc = -1;
    int p1_rise = -1;
    logic [7:0] last_code = 8'h00;
    logic p1_up_q = 1'b0;

    ps2_player_keys #(.FILTER_LEN(8), .TIMEOUT_CYC(2500)) dut (
        .clk(clk), .rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
        .o_p1_up(o_p1_up), .o_p1_down(o_p1_down), .o_p1_left(o_p1_left),
        .o_p1_right(o_p1_right), .o_p1_fire(o_p1_fire),
        .o_p2_up(o_p2_up), .o_p2_down(o_p2_down), .o_p2_left(o_p2_left),
        .o_p2_right(o_p2_right), .o_p2_fire(o_p2_fire),
        .o_scan_code(o_scan_code), .o_scan_valid(o_scan_valid), .o_frame_err(o_frame_err)
    );

    assign keys = {o_p2_fire, o_p2_right, o_p2_left, o_p2_down, o_p2_up,
                   o_p1_fire, o_p1_right, o_p1_left, o_p1_down, o_p1_up};

    always #20 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_scan_valid) begin
            n_valid = n_valid + 1;
            vcyc = cyc;
            last_code = o_scan_code;
        end
        if (o_frame_err) n_err = n_err + 1;
        if (o_p1_up && !p1_up_q && p1_rise < 0) p1_rise = cyc;
        p1_up_q = o_p1_up;
    end

    task automatic send_raw(input logic [7:0] b, input logic bad_par, input int nedges);
        logic [10:0] bits;
        bits = {1'b1, bad_par ^ ~(^b), b, 1'b0};
        for (int i = 0; i < nedges; i++) begin
            ps2_dat = bits[i];
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (IDLE) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, 1'b0, 11);
    endtask

    task automatic check_keys(input string name, input logic [9:0] exp);
        total++;
        if (keys !== exp) begin
            bad++;
            $display("FAIL %s: keys got %h want %h", name, keys, exp);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        check_keys("reset_keys", 10'h000);
        total++;
        if (o_scan_code !== 8'h00) begin bad++; $display("FAIL reset_code: got %h want 00", o_scan_code); end
        total++;
        if (o_scan_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_scan_valid); end
        total++;
        if (o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_make;
        int v0;
        v0 = n_valid;
        send(8'h1D);
        total++;
        if (n_valid - v0 !== 1) begin bad++; $display("FAIL make_valid_count: got %0d want 1", n_valid - v0); end
        total++;
        if (last_code !== 8'h1D) begin bad++; $display("FAIL make_code: got %h want 1d", last_code); end
        total++;
        if (p1_rise !== vcyc + 1) begin bad++; $display("FAIL make_latency: rise %0d want %0d", p1_rise, vcyc + 1); end
        check_keys("make_1d", 10'h001);
    endtask

    task automatic test_extended;
        send(8'hE0);
        check_keys("ext_prefix_only", 10'h001);
        send(8'h75);
        check_keys("ext_make_up", 10'h021);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_keys("ext_break_up", 10'h001);
    endtask

    task automatic test_parity;
        int v0, e0;
        send(8'hF0);
        send(8'h1D);
        check_keys("break_1d", 10'h000);
        v0 = n_valid;
        e0 = n_err;
        send_raw(8'h1D, 1'b1, 11);
        total++;
        if (n_err - e0 !== 1) begin bad++; $display("FAIL parity_err: got %0d want 1", n_err - e0); end
        total++;
        if (n_valid - v0 !== 0) begin bad++; $display("FAIL parity_valid: got %0d want 0", n_valid - v0); end
        check_keys("parity_keys", 10'h000);
    endtask

    task automatic test_timeout;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_raw(8'h1D, 1'b0, 4);
        total++;
        if (n_err - e0 !== 0) begin bad++; $display("FAIL timeout_early: got %0d want 0", n_err - e0); end
        repeat (2600) @(negedge clk);
        total++;
        if (n_err - e0 !== 1) begin bad++; $display("FAIL timeout_err: got %0d want 1", n_err - e0); end
        total++;
        if (n_valid - v0 !== 0) begin bad++; $display("FAIL timeout_valid: got %0d want 0", n_valid - v0); end
        send(8'h29);
        check_keys("after_timeout_fire", 10'h010);
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        ps2_dat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_dat = 1'b1;
        repeat (3000) @(negedge clk);
        total++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin
            bad++;
            $display("FAIL glitch_events: valid %0d err %0d want 0 0", n_valid - v0, n_err - e0);
        end
        check_keys("glitch_keys", 10'h010);
        send(8'hF0);
        send(8'h29);
        total++;
        if (n_valid - v0 !== 2) begin bad++; $display("FAIL glitch_after_valid: got %0d want 2", n_valid - v0); end
        check_keys("glitch_after_keys", 10'h000);
    endtask

    task automatic test_decoder_edges;
        send(8'hE0);
        send(8'h5A);
        check_keys("kp_enter_no_fire", 10'h000);
        send(8'h5A);
        check_keys("enter_fire", 10'h200);
        send(8'hE0);
        send(8'hF0);
        send(8'h5A);
        check_keys("kp_enter_break_ignored", 10'h200);
        send(8'hF0);
        send(8'h5A);
        check_keys("enter_release", 10'h000);
        send(8'hE0);
        send_raw(8'h75, 1'b1, 11);
        send(8'h75);
        check_keys("prefix_survives_err", 10'h020);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'hAA);
        send(8'h1D);
        send(8'h1B);
        check_keys("opposite_dirs", 10'h003);
        send(8'h1D);
        check_keys("typematic", 10'h003);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check_keys("pause_skipped", 10'h003);
        send(8'hF0);
        send(8'h1B);
        check_keys("after_pause_break", 10'h001);
    endtask

    task automatic test_reset_mid;
        send(8'h1C);
        check_keys("held_w_a", 10'h005);
        send_raw(8'h23, 1'b0, 3);
        #5 rst_n = 1'b0;
        #1;
        check_keys("async_reset_keys", 10'h000);
        total++;
        if (o_scan_code !== 8'h00) begin bad++; $display("FAIL async_reset_code: got %h want 00", o_scan_code); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h23);
        check_keys("post_reset_right", 10'h008);
    endtask

    initial begin
        test_reset;
        test_make;
        test_extended;
        test_parity;
        test_timeout;
        test_glitch;
        test_decoder_edges;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
